wptr_full: RTL and testbench
============================

WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001: The module SHALL have parameter ADRRSIZE, default 3, giving the address width; FIFO depth is 2^ADRRSIZE; legal range ADRRSIZE >= 2.
REQ-002: The module SHALL have parameter AFULL_LEVEL, default 6, giving the occupancy at or above which walmost_full asserts; legal range 1..2^ADRRSIZE.
REQ-003: wclk  input  1  write-domain clock; the block SHALL use this single clock only.
REQ-004: wrst  input  1  reset, synchronous to wclk, active-high.
REQ-005: winc  input  1  write request for the current cycle.
REQ-006: rptr_gray  input  ADRRSIZE+1  read pointer in Gray code, asynchronous to wclk.
REQ-007: wen  output  1  memory write strobe, combinational: winc AND NOT wfull.
REQ-008: waddr  output  ADRRSIZE  memory write address: low ADRRSIZE bits of the binary write pointer.
REQ-009: wptr_gray  output  ADRRSIZE+1  registered Gray write pointer, for the read-side synchronizer.
REQ-010: wfull  output  1  registered full flag.
REQ-011: walmost_full  output  1  registered almost-full flag.
REQ-012: wcount  output  ADRRSIZE+1  registered occupancy as seen from the write domain, range 0..2^ADRRSIZE.
REQ-013: wovf  output  1  sticky overflow flag.

Function
REQ-014: rptr_gray SHALL pass through a two-stage synchronizer (rq1, rq2) clocked by wclk before any use.
REQ-015: The accept condition SHALL be winc AND NOT wfull; only an accepted write advances the pointer.
REQ-016: The next binary pointer SHALL be wbin + accept, modulo 2^(ADRRSIZE+1); the next Gray pointer SHALL be next_bin XOR (next_bin >> 1).
REQ-017: wbin and wptr_gray SHALL update together on every wclk edge, so wptr_gray changes by at most one bit per cycle.
REQ-018: At the same edge, wfull SHALL load (next_gray == {~rq2[ADRRSIZE:ADRRSIZE-1], rq2[ADRRSIZE-2:0]}).
REQ-019: wcount SHALL load next_bin minus the Gray-to-binary conversion of rq2, modulo 2^(ADRRSIZE+1).
REQ-020: walmost_full SHALL load (that same next occupancy >= AFULL_LEVEL).
REQ-021: wfull SHALL be asserted in the cycle after the write that fills the FIFO; a winc while wfull=1 SHALL NOT be accepted, and waddr and wptr_gray SHALL remain unchanged.
REQ-022: A winc while wfull=1 SHALL set wovf; wovf SHALL stay set until reset.
REQ-023: A change on rptr_gray SHALL reach wfull, walmost_full and wcount 3 wclk edges later: rq1, rq2, then the flag register.
REQ-024: Pointer wrap from 2^(ADRRSIZE+1)-1 to 0 SHALL be seamless: no spurious full, and wcount stays correct across the wrap.
REQ-025: If a freeing read and a write coincide, the flags SHALL reflect both within the latency of REQ-023; wfull is conservative, never late-asserting.

Reset
REQ-026: When wrst=1 at a wclk edge, wbin, wptr_gray, rq1, rq2, wcount, wfull, walmost_full and wovf SHALL all become 0.
REQ-027: During reset, wen SHALL be 0 regardless of winc.
REQ-028: Reset asserted mid-operation SHALL discard pointer state with no partial update; the read side is reset concurrently.

Structure
REQ-029: A shared package SHALL hold the Gray-to-binary and binary-to-Gray functions and the default ADRRSIZE value.
REQ-030: The two-stage synchronizer SHALL be a separate sub-module, sync_r2w, with ports wclk, wrst, rptr_gray and wq2_rptr.
REQ-031: All flag logic SHALL be registered; no output other than wen may be combinational from inputs.

Verification (ADRRSIZE=3, AFULL_LEVEL=6)
REQ-032: Reset -> after release, wptr_gray=0000, waddr=0, wcount=0, wfull=0, walmost_full=0, wovf=0.
REQ-033: rptr_gray=0000; 6 cycles of winc=1 -> walmost_full=1 in the cycle after the 6th write, wcount=6.
REQ-034: rptr_gray=0000; 8 cycles of winc=1 -> wfull=1 and wcount=8 in the cycle after the 8th write, wptr_gray=1100.
REQ-035: With wfull=1, winc=1 for 2 cycles -> wen=0, wptr_gray stays 1100, and wovf=1 from the next cycle onward.
REQ-036: Full FIFO, rptr_gray set to 0110 (binary 4) -> 3 edges later wfull=0, walmost_full=0, wcount=4.
REQ-037: Wrap test: 40 writes with rptr_gray trailing by 3 -> wcount=3 throughout, wfull never set, and wptr_gray follows the Gray sequence across 1000 -> 0000.

Source files
------------

// File: rtl/wptr_full_pkg.sv
// Shared pointer helpers for the write-side FIFO pointer/flag logic.
package wptr_full_pkg;

    localparam int unsigned DEFAULT_ADRRSIZE = 3;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int unsigned i = 31; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the write clock domain.
module sync_r2w
    import wptr_full_pkg::*;
#(
    parameter int unsigned ADRRSIZE = DEFAULT_ADRRSIZE
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [ADRRSIZE:0]   rptr_gray,
    output logic [ADRRSIZE:0]   wq2_rptr
);

    logic [ADRRSIZE:0] rq1;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            rq1      <= '0;
            wq2_rptr <= '0;
        end else begin
            rq1      <= rptr_gray;
            wq2_rptr <= rq1;
        end
    end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, full/almost-full flags, occupancy and sticky overflow for an async FIFO.
module wptr_full
    import wptr_full_pkg::*;
#(
    parameter int unsigned ADRRSIZE    = DEFAULT_ADRRSIZE,
    parameter int unsigned AFULL_LEVEL = 6
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADRRSIZE:0]   rptr_gray,
    output logic                wen,
    output logic [ADRRSIZE-1:0] waddr,
    output logic [ADRRSIZE:0]   wptr_gray,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADRRSIZE:0]   wcount,
    output logic                wovf
);

    localparam int unsigned PW = ADRRSIZE + 1;
    localparam logic [ADRRSIZE:0] AFULL_CNT = PW'(AFULL_LEVEL);

    logic [ADRRSIZE:0] rq2;
    logic [ADRRSIZE:0] wbin;
    logic [ADRRSIZE:0] next_bin;
    logic [ADRRSIZE:0] next_gray;
    logic [ADRRSIZE:0] rbin;
    logic [ADRRSIZE:0] next_count;
    logic [ADRRSIZE:0] full_gray;

    sync_r2w #(
        .ADRRSIZE (ADRRSIZE)
    ) u_sync_r2w (
        .wclk      (wclk),
        .wrst      (wrst),
        .rptr_gray (rptr_gray),
        .wq2_rptr  (rq2)
    );

    assign wen   = winc & ~wfull & ~wrst;
    assign waddr = wbin[ADRRSIZE-1:0];

    always_comb begin
        next_bin   = wbin + {{ADRRSIZE{1'b0}}, wen};
        next_gray  = PW'(bin2gray(32'(next_bin)));
        rbin       = PW'(gray2bin(32'(rq2)));
        next_count = next_bin - rbin;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        full_gray  = {~rq2[ADRRSIZE:ADRRSIZE-1], rq2[ADRRSIZE-2:0]};
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= next_bin;
            wptr_gray    <= next_gray;
            wfull        <= (next_gray == full_gray);
            walmost_full <= (next_count >= AFULL_CNT);
            wcount       <= next_count;
            wovf         <= wovf | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADRRSIZE=3, AFULL_LEVEL=6) against an occupancy-level model.
module tb_wptr_full;

    logic       clk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [3:0] rptr_gray;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wcount;
    logic       wovf;

    wptr_full #(
        .ADRRSIZE    (3),
        .AFULL_LEVEL (6)
    ) dut (
        .wclk         (clk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .wovf         (wovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    // Model: accepted-write count, read-pointer samples seen via the two-edge synchronizer.
    int m_wr = 0, r1 = 0, r2 = 0, m_count = 0;
    bit m_full = 0, m_afull = 0, m_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_to_int(input logic [3:0] g);
        for (int i = 0; i < 16; i++)
            if (gray_tab[i] == int'(g)) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (wrst) begin
            m_wr = 0; r1 = 0; r2 = 0; m_count = 0;
            m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (winc && m_full) m_ovf = 1;
            if (winc && !m_full) m_wr = (m_wr + 1) % 16;
            m_count = (m_wr - r2 + 16) % 16;
            m_full  = (m_count == 8);
            m_afull = (m_count >= 6);
            r2 = r1;
            r1 = gray_to_int(rptr_gray);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wen",          32'(wen),          32'(winc && !m_full && !wrst));
            check("waddr",        32'(waddr),        32'(m_wr % 8));
            check("wptr_gray",    32'(wptr_gray),    32'(gray_tab[m_wr]));
            check("wfull",        32'(wfull),        32'(m_full));
            check("walmost_full", 32'(walmost_full), 32'(m_afull));
            check("wcount",       32'(wcount),       32'(m_count));
            check("wovf",         32'(wovf),         32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rd;
        winc = 0; rptr_gray = 0; wrst = 1;
        tick();
        chk_en = 1;
        tick();
        wrst = 0;
        check("rst_wptr_gray", 32'(wptr_gray), 0);
        check("rst_waddr",     32'(waddr), 0);
        check("rst_wcount",    32'(wcount), 0);
        check("rst_flags",     32'({wfull, walmost_full, wovf}), 0);

        winc = 1;
        repeat (6) tick();
        check("afull_at_6",  32'(walmost_full), 1);
        check("count_at_6",  32'(wcount), 6);
        check("nofull_at_6", 32'(wfull), 0);
        repeat (2) tick();
        check("full_at_8",   32'(wfull), 1);
        check("count_at_8",  32'(wcount), 8);
        check("gray_at_8",   32'(wptr_gray), 32'b1100);
        check("wen_blocked", 32'(wen), 0);
        tick();
        check("ovf_set",     32'(wovf), 1);
        check("gray_hold1",  32'(wptr_gray), 32'b1100);
        tick();
        check("gray_hold2",  32'(wptr_gray), 32'b1100);
        check("waddr_hold",  32'(waddr), 0);
        check("ovf_sticky",  32'(wovf), 1);

        winc = 0; rptr_gray = 4'b0110;
        tick();
        check("full_lat1", 32'(wfull), 1);
        tick();
        check("full_lat2", 32'(wfull), 1);
        tick();
        check("full_clr",   32'(wfull), 0);
        check("afull_clr",  32'(walmost_full), 0);
        check("count_rd4",  32'(wcount), 4);
        check("ovf_kept",   32'(wovf), 1);

        wrst = 1; rptr_gray = 0;
        tick(); tick();
        wrst = 0;
        check("ovf_reset", 32'(wovf), 0);
        for (int i = 0; i < 40; i++) begin
            winc = 1;
            rptr_gray = 4'(gray_tab[i % 16]);
            tick();
            check("wrap_gray", 32'(wptr_gray), 32'(gray_tab[(i + 1) % 16]));
            if (i >= 2) check("wrap_count", 32'(wcount), 3);
            check("wrap_nofull", 32'(wfull), 0);
            if ((i + 1) % 16 == 15) check("wrap_gray_1000", 32'(wptr_gray), 32'b1000);
            if ((i + 1) % 16 == 0)  check("wrap_gray_0000", 32'(wptr_gray), 0);
        end

        winc = 0; wrst = 1; rptr_gray = 0; rd = 0;
        tick(); tick();
        wrst = 0;
        for (int c = 0; c < 900; c++) begin
            int wbias, rbias;
            wbias = ((c / 100) % 2 == 1) ? 3 : 1;
            rbias = 4 - wbias;
            if ($urandom_range(0, 299) == 0) begin
                wrst = 1; rd = 0; rptr_gray = 0;
                winc = $urandom_range(0, 1) == 1;
                tick();
                wrst = 0;
            end else begin
                winc = $urandom_range(0, 3) < wbias;
                if (rd != m_wr && $urandom_range(0, 3) < rbias) rd = (rd + 1) % 16;
                rptr_gray = 4'(gray_tab[rd]);
                tick();
            end
        end

        winc = 0;
        tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
